// File: rtl/imem_loader.sv
// Boot-time program loader: streams words into instruction memory at
// BASE_ADDR + n*STRIDE and holds the core in reset until the load settles.
module imem_loader #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h4,
    parameter int                STRIDE    = 4,
    parameter int                DEPTH     = 1024,
    parameter int                RST_HOLD  = 4,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE_C  = ADDR_W'(STRIDE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic                s_ready_reg, s_ready_next;
    logic                mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                core_rst_reg, core_rst_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_ovf_reg, err_ovf_next;
    logic [CNT_W-1:0]    word_cnt_reg, word_cnt_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic                beat;

    // s_ready is registered, so a beat is judged against last cycle's decision.
    assign beat = s_valid & s_ready_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            s_ready_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= '0;
            core_rst_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_ovf_reg   <= 1'b0;
            word_cnt_reg  <= '0;
            ptr_reg       <= BASE_ADDR;
            hold_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            s_ready_reg   <= s_ready_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            core_rst_reg  <= core_rst_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_ovf_reg   <= err_ovf_next;
            word_cnt_reg  <= word_cnt_next;
            ptr_reg       <= ptr_next;
            hold_reg      <= hold_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        s_ready_next   = s_ready_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        core_rst_next  = core_rst_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        err_ovf_next   = err_ovf_reg;
        word_cnt_next  = word_cnt_reg;
        ptr_next       = ptr_reg;
        hold_next      = hold_reg;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next    = ST_LOAD;
                    s_ready_next  = 1'b1;
                    busy_next     = 1'b1;
                    done_next     = 1'b0;
                    err_ovf_next  = 1'b0;
                    core_rst_next = 1'b1;
                    word_cnt_next = '0;
                    ptr_next      = BASE_ADDR;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (word_cnt_reg == DEPTH_C) begin
                        // Overflow: drop the word, keep the core in reset.
                        state_next   = ST_ERR;
                        s_ready_next = 1'b0;
                        busy_next    = 1'b0;
                        err_ovf_next = 1'b1;
                    end else begin
                        mem_we_next    = 1'b1;
                        mem_addr_next  = ptr_reg;
                        mem_wdata_next = s_data;
                        word_cnt_next  = word_cnt_reg + 1'b1;
                        ptr_next       = ptr_reg + STRIDE_C;
                        if (s_last) begin
                            state_next   = ST_RELEASE;
                            s_ready_next = 1'b0;
                            hold_next    = HOLD_INIT;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                // Hold counts down from the final write cycle.
                if (hold_reg == '0) begin
                    state_next    = ST_DONE;
                    core_rst_next = 1'b0;
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                end else begin
                    hold_next = hold_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign s_ready   = s_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign core_rst  = core_rst_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err_ovf   = err_ovf_reg;
    assign word_cnt  = word_cnt_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as beats are
// offered and retired by a monitor watching mem_we.
module tb_imem_loader;

    localparam int DEPTH    = 4;
    localparam int RST_HOLD = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err_ovf;
    logic [2:0]  word_cnt;

    imem_loader #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .BASE_ADDR(32'h4),
        .STRIDE   (4),
        .DEPTH    (DEPTH),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err_ovf  (err_ovf),
        .word_cnt (word_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    int          exp_cnt = 0;
    logic [31:0] exp_addr = 32'h4;
    logic [31:0] prog [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Write monitor: every mem_we pulse must retire the oldest queued write.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            wr_t e;
            we_cnt++;
            if (sb.size() == 0) begin
                check_val("unexpected_we", mem_addr, 64'hffff_ffff_ffff_ffff);
            end else begin
                e = sb.pop_front();
                check_val("wr_addr", mem_addr, e.addr);
                check_val("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        exp_cnt  = 0;
        exp_addr = 32'h4;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_s_ready"}, s_ready, 0);
        check_val({pfx, "_mem_we"}, mem_we, 0);
        check_val({pfx, "_mem_addr"}, mem_addr, 32'h4);
        check_val({pfx, "_mem_wdata"}, mem_wdata, 0);
        check_val({pfx, "_core_rst"}, core_rst, 1);
        check_val({pfx, "_busy"}, busy, 0);
        check_val({pfx, "_done"}, done, 0);
        check_val({pfx, "_err_ovf"}, err_ovf, 0);
        check_val({pfx, "_word_cnt"}, word_cnt, 0);
    endtask

    // Offer one word until accepted; the model decides whether it is written or dropped.
    task automatic send_word(input logic [31:0] data, input logic last);
        bit accepted = 0;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        for (int t = 0; t < 40 && !accepted; t++) begin
            if (s_ready === 1'b1) begin
                accepted = 1;
                if (exp_cnt < DEPTH) begin
                    sb.push_back('{addr: exp_addr, data: data});
                    exp_addr += 32'd4;
                    exp_cnt++;
                end
            end
            cycle();
        end
        if (!accepted) check_val("ready_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called right after the final write edge; counts edges until core_rst drops.
    task automatic wait_done(input string tag, input bit poke);
        int k = 0;
        while (core_rst !== 1'b0 && k < 40) begin
            start = poke && (k < 2);
            cycle();
            k++;
        end
        start = 1'b0;
        check_val({tag, "_hold"}, k, RST_HOLD);
        check_val({tag, "_done"}, done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int we_base;
        prog[0] = 32'h00500093;
        prog[1] = 32'h00a00113;
        prog[2] = 32'h002081b3;
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;

        // 1: basic three-word load
        repeat (3) cycle();
        check_reset_vals("t1_reset");
        rst = 1'b1;
        cycle();
        we_base = we_cnt;
        pulse_start();
        check_val("t1_busy", busy, 1);
        check_val("t1_s_ready", s_ready, 1);
        for (int i = 0; i < 3; i++) send_word(prog[i], i == 2);
        wait_done("t1", 0);
        check_val("t1_word_cnt", word_cnt, 3);
        check_val("t1_we_count", we_cnt - we_base, 3);

        // 2: reload with random valid gaps
        we_base = we_cnt;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 3)) cycle();
            send_word(prog[i], i == 2);
        end
        wait_done("t2", 0);
        check_val("t2_we_count", we_cnt - we_base, 3);

        // 3: overflow past DEPTH without s_last
        we_base = we_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + i, 1'b0);
        check_val("t3_err_ovf", err_ovf, 1);
        check_val("t3_core_rst", core_rst, 1);
        check_val("t3_s_ready", s_ready, 0);
        check_val("t3_word_cnt", word_cnt, 4);
        repeat (2) cycle();
        check_val("t3_we_count", we_cnt - we_base, 4);

        // 3b: from ERR, exactly DEPTH words with s_last on the last is a legal fill
        pulse_start();
        check_val("t3b_err_clr", err_ovf, 0);
        for (int i = 0; i < 4; i++) send_word(32'hB000_0000 + i, i == 3);
        wait_done("t3b", 0);
        check_val("t3b_word_cnt", word_cnt, 4);
        check_val("t3b_err_ovf", err_ovf, 0);

        // 4: asynchronous reset mid-load
        pulse_start();
        send_word(32'hC000_0000, 1'b0);
        send_word(32'hC000_0001, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("t4_async");
        repeat (2) cycle();
        rst = 1'b1;
        pulse_start();
        send_word(32'hC000_0002, 1'b1);
        wait_done("t4", 0);
        check_val("t4_word_cnt", word_cnt, 1);

        // 5: reload from DONE
        pulse_start();
        check_val("t5_core_rst", core_rst, 1);
        check_val("t5_done", done, 0);
        check_val("t5_word_cnt0", word_cnt, 0);
        send_word(32'hD000_0000, 1'b0);
        send_word(32'hD000_0001, 1'b1);
        wait_done("t5", 0);
        check_val("t5_word_cnt", word_cnt, 2);

        // 6: start pulses during LOAD and RELEASE are ignored
        we_base = we_cnt;
        pulse_start();
        start = 1'b1;
        repeat (2) cycle();
        start = 1'b0;
        check_val("t6_load_cnt", word_cnt, 0);
        check_val("t6_load_busy", busy, 1);
        send_word(32'hE000_0000, 1'b1);
        wait_done("t6", 1);
        check_val("t6_word_cnt", word_cnt, 1);
        repeat (3) cycle();
        check_val("t6_still_done", done, 1);
        check_val("t6_we_count", we_cnt - we_base, 1);

        check_val("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
